// File: rtl/thor2024_fpu_sequencer_pkg.sv
// thor2024_fpu_sequencer_pkg -- shared types for the FPU sequencer slice.
// Rev 1.0
`default_nettype none
package thor2024_fpu_sequencer_pkg;

  localparam int c_QUE_ENTRIES = 16;
  localparam int c_QUE_NDXW    = $clog2(c_QUE_ENTRIES);

  typedef logic [c_QUE_NDXW-1:0]    que_ndx_t;
  typedef logic [c_QUE_ENTRIES-1:0] que_bitmask_t;

  typedef enum logic [2:0] {
    FOC_ADD  = 3'd0,
    FOC_MUL  = 3'd1,
    FOC_CVT  = 3'd2,
    FOC_DIV  = 3'd3,
    FOC_SQRT = 3'd4
  } fpu_op_class_t;

  typedef enum logic [1:0] {
    FSS_IDLE    = 2'd0,
    FSS_EXEC    = 2'd1,
    FSS_FLUSH   = 2'd2,
    FSS_WAIT_WB = 2'd3
  } fpu_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/thor2024_fpu_sequencer_if.sv
// thor2024_fpu_sequencer_if -- issue / datapath / writeback signals of the FPU sequencer.
// Rev 1.0
`default_nettype none
interface thor2024_fpu_sequencer_if;
  import thor2024_fpu_sequencer_pkg::*;

  logic          issue_v;
  que_ndx_t      issue_ndx;
  fpu_op_class_t issue_op;
  que_bitmask_t  cancel;
  logic          fpu_idle;
  logic          fpu_start;
  fpu_op_class_t fpu_op;
  que_ndx_t      busy_ndx;
  logic          wb_req;
  que_ndx_t      wb_ndx;
  logic          wb_exc;
  logic          wb_ack;

  modport master (
    output issue_v, issue_ndx, issue_op, cancel, wb_ack,
    input  fpu_idle, fpu_start, fpu_op, busy_ndx, wb_req, wb_ndx, wb_exc
  );

  modport slave (
    input  issue_v, issue_ndx, issue_op, cancel, wb_ack,
    output fpu_idle, fpu_start, fpu_op, busy_ndx, wb_req, wb_ndx, wb_exc
  );

endinterface
`default_nettype wire

// File: rtl/thor2024_fpu_lat_lookup.sv
// thor2024_fpu_lat_lookup -- class-to-latency map; div/sqrt flagged illegal unless
// THOR_FPU_DIVSQRT_EN is defined. Rev 1.0
`default_nettype none
module thor2024_fpu_lat_lookup
  import thor2024_fpu_sequencer_pkg::*;
#(
  parameter int LAT_ADD  = 4,
  parameter int LAT_MUL  = 5,
  parameter int LAT_CVT  = 3,
`ifdef THOR_FPU_DIVSQRT_EN
  parameter int LAT_DIV  = 24,
  parameter int LAT_SQRT = 32,
`endif
  parameter int CNTW     = 6
) (
  input  fpu_op_class_t   i_op,
  output logic [CNTW-1:0] o_lat,
  output logic            o_illegal
);

  always_comb begin
    o_lat     = CNTW'(LAT_ADD);
    o_illegal = 1'b0;
    case (i_op)
      FOC_ADD:  o_lat = CNTW'(LAT_ADD);
      FOC_MUL:  o_lat = CNTW'(LAT_MUL);
      FOC_CVT:  o_lat = CNTW'(LAT_CVT);
`ifdef THOR_FPU_DIVSQRT_EN
      FOC_DIV:  o_lat = CNTW'(LAT_DIV);
      FOC_SQRT: o_lat = CNTW'(LAT_SQRT);
`else
      // One-cycle pass-through so the exception reaches writeback after E+1
      FOC_DIV, FOC_SQRT: begin
        o_lat     = CNTW'(1);
        o_illegal = 1'b1;
      end
`endif
      default: o_lat = CNTW'(LAT_ADD);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/thor2024_fpu_sequencer.sv
// thor2024_fpu_sequencer -- sequences the shared FPU datapath and result-bus handshake.
// THOR_FPU_DIVSQRT_EN enables div/sqrt sequencing. Rev 1.0
`default_nettype none
module thor2024_fpu_sequencer
  import thor2024_fpu_sequencer_pkg::*;
#(
  parameter int LAT_ADD  = 4,
  parameter int LAT_MUL  = 5,
  parameter int LAT_CVT  = 3,
`ifdef THOR_FPU_DIVSQRT_EN
  parameter int LAT_DIV  = 24,
  parameter int LAT_SQRT = 32,
`endif
  parameter int CNTW     = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  thor2024_fpu_sequencer_if.slave   sif
);

  fpu_seq_state_t  r_state, w_state;
  logic [CNTW-1:0] r_cnt, w_cnt;
  logic            r_exc_pend, w_exc_pend;
  que_ndx_t        r_busy_ndx, w_busy_ndx;
  fpu_op_class_t   r_op, w_op;
  logic            w_start;
  logic            r_start, r_idle, r_wb_req, r_wb_exc;
  que_ndx_t        r_wb_ndx;

  logic [CNTW-1:0] w_lat;
  logic            w_illegal;
  logic            w_cnt_term;
  logic            w_cancel_issue;
  logic            w_cancel_busy;

  thor2024_fpu_lat_lookup #(
    .LAT_ADD  (LAT_ADD),
    .LAT_MUL  (LAT_MUL),
    .LAT_CVT  (LAT_CVT),
`ifdef THOR_FPU_DIVSQRT_EN
    .LAT_DIV  (LAT_DIV),
    .LAT_SQRT (LAT_SQRT),
`endif
    .CNTW     (CNTW)
  ) u_lat (
    .i_op      (sif.issue_op),
    .o_lat     (w_lat),
    .o_illegal (w_illegal)
  );

  assign w_cnt_term     = (r_cnt == CNTW'(1));
  assign w_cancel_issue = sif.cancel[sif.issue_ndx];
  assign w_cancel_busy  = sif.cancel[r_busy_ndx];

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_exc_pend = r_exc_pend;
    w_busy_ndx = r_busy_ndx;
    w_op       = r_op;
    w_start    = 1'b0;
    case (r_state)
      FSS_IDLE: begin
        if (sif.issue_v) begin
          w_busy_ndx = sif.issue_ndx;
          w_op       = sif.issue_op;
          w_cnt      = w_lat;
          w_exc_pend = w_illegal;
          w_start    = ~w_illegal;
          w_state    = w_cancel_issue ? FSS_FLUSH : FSS_EXEC;
        end
      end
      FSS_EXEC: begin
        w_cnt = r_cnt - CNTW'(1);
        // A flush landing on the terminal cycle has nothing left to drain
        if (w_cancel_busy)   w_state = w_cnt_term ? FSS_IDLE : FSS_FLUSH;
        else if (w_cnt_term) w_state = FSS_WAIT_WB;
      end
      FSS_FLUSH: begin
        w_cnt = r_cnt - CNTW'(1);
        if (w_cnt_term) w_state = FSS_IDLE;
      end
      FSS_WAIT_WB: begin
        if (sif.wb_ack || w_cancel_busy) w_state = FSS_IDLE;
      end
      default: w_state = FSS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FSS_IDLE;
      r_cnt      <= '0;
      r_exc_pend <= 1'b0;
      r_busy_ndx <= '0;
      r_op       <= FOC_ADD;
      r_start    <= 1'b0;
      r_idle     <= 1'b1;
      r_wb_req   <= 1'b0;
      r_wb_exc   <= 1'b0;
      r_wb_ndx   <= '0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_exc_pend <= w_exc_pend;
      r_busy_ndx <= w_busy_ndx;
      r_op       <= w_op;
      r_start    <= w_start;
      r_idle     <= (w_state == FSS_IDLE);
      r_wb_req   <= (w_state == FSS_WAIT_WB);
      r_wb_exc   <= (w_state == FSS_WAIT_WB) && w_exc_pend;
      r_wb_ndx   <= w_busy_ndx;
    end
  end

  assign sif.fpu_idle  = r_idle;
  assign sif.fpu_start = r_start;
  assign sif.fpu_op    = r_op;
  assign sif.busy_ndx  = r_busy_ndx;
  assign sif.wb_req    = r_wb_req;
  assign sif.wb_ndx    = r_wb_ndx;
  assign sif.wb_exc    = r_wb_exc;

endmodule
`default_nettype wire

// File: tb/tb_thor2024_fpu_sequencer.sv
// tb_thor2024_fpu_sequencer -- vector table plus writeback scoreboard for the FPU sequencer.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps
module tb_thor2024_fpu_sequencer;
  import thor2024_fpu_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  thor2024_fpu_sequencer_if sif();

  thor2024_fpu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .sif (sif.slave)
  );

  typedef struct {
    fpu_op_class_t op;
    int            ndx;
    int            cancel_edge;
    int            cancel_ndx;
    int            ack_edge;
    int            spur_edge;
    bit            exp_start;
    bit            exp_wb;
    bit            exp_exc;
    int            exp_wb_rel;
    int            exp_idle;
  } vec_t;

  typedef struct {
    int ndx;
    bit exc;
    int due;
  } sb_t;

  vec_t vecs[12];
  int   nvec = 0;
  sb_t  sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   prev_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_vec(input fpu_op_class_t op, input int ndx, input int cancel_edge,
                         input int cancel_ndx, input int ack_edge, input int spur_edge,
                         input bit exp_start, input bit exp_wb, input bit exp_exc,
                         input int exp_wb_rel, input int exp_idle);
    vecs[nvec].op          = op;
    vecs[nvec].ndx         = ndx;
    vecs[nvec].cancel_edge = cancel_edge;
    vecs[nvec].cancel_ndx  = cancel_ndx;
    vecs[nvec].ack_edge    = ack_edge;
    vecs[nvec].spur_edge   = spur_edge;
    vecs[nvec].exp_start   = exp_start;
    vecs[nvec].exp_wb      = exp_wb;
    vecs[nvec].exp_exc     = exp_exc;
    vecs[nvec].exp_wb_rel  = exp_wb_rel;
    vecs[nvec].exp_idle    = exp_idle;
    nvec++;
  endtask

  // Writeback monitor: every rising wb_req must match the oldest pushed expectation
  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (sif.wb_req && !prev_req) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wb_unexpected: got wb_req=1 ndx=%0d expected no request (cycle %0d)",
                   sif.wb_ndx, cyc);
        end else begin
          sb_t s;
          s = sb.pop_front();
          chk("wb_ndx", 32'(sif.wb_ndx), s.ndx);
          chk("wb_busy_ndx", 32'(sif.busy_ndx), s.ndx);
          chk("wb_exc", 32'(sif.wb_exc), 32'(s.exc));
          chk("wb_time", cyc, s.due);
        end
      end
      prev_req = sif.wb_req;
    end
  end

  task automatic run_vec(input vec_t v, input int id);
    int           e;
    int           seen;
    bit           late_start;
    que_bitmask_t m;
    sb_t          s;
    m = '0;
    m[v.cancel_ndx] = 1'b1;
    @(negedge clk);
    e = cyc + 1;
    sif.issue_v   = 1'b1;
    sif.issue_ndx = que_ndx_t'(v.ndx);
    sif.issue_op  = v.op;
    sif.cancel    = (v.cancel_edge == 0) ? m : '0;
    sif.wb_ack    = (v.ack_edge <= 0);
    if (v.exp_wb) begin
      s.ndx = v.ndx;
      s.exc = v.exp_exc;
      s.due = e + v.exp_wb_rel;
      sb.push_back(s);
    end
    seen = -1;
    late_start = 1'b0;
    for (int r = 0; r < 100 && seen < 0; r++) begin
      @(negedge clk);
      if (r == 0) begin
        chk($sformatf("v%0d_start", id), 32'(sif.fpu_start), 32'(v.exp_start));
        chk($sformatf("v%0d_idle_low", id), 32'(sif.fpu_idle), 0);
        if (v.exp_start) chk($sformatf("v%0d_fpu_op", id), 32'(sif.fpu_op), 32'(v.op));
      end else begin
        if (sif.fpu_start) late_start = 1'b1;
        if (sif.fpu_idle) seen = r;
      end
      sif.issue_v   = (r + 1 == v.spur_edge);
      sif.issue_ndx = que_ndx_t'(11);
      sif.issue_op  = FOC_ADD;
      sif.cancel    = (r + 1 == v.cancel_edge) ? m : '0;
      sif.wb_ack    = (r + 1 >= v.ack_edge);
    end
    sif.issue_v = 1'b0;
    sif.cancel  = '0;
    sif.wb_ack  = 1'b0;
    chk($sformatf("v%0d_late_start", id), 32'(late_start), 0);
    chk($sformatf("v%0d_idle_edge", id), seen, v.exp_idle);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    sif.issue_v   = 1'b0;
    sif.issue_ndx = '0;
    sif.issue_op  = FOC_ADD;
    sif.cancel    = '0;
    sif.wb_ack    = 1'b0;

    //       op        ndx cEdg cNdx ack spur start wb exc wbRel idle
    add_vec(FOC_ADD,   5,  -1,  0,   0,  -1,  1,    1, 0,  4,    5);
    add_vec(FOC_MUL,   1,  -1,  0,   12,  8,  1,    1, 0,  5,    12);
    add_vec(FOC_CVT,   7,  -1,  0,   3,  -1,  1,    1, 0,  3,    4);
    add_vec(FOC_ADD,   3,   0,  3,   99, -1,  1,    0, 0,  0,    4);
    add_vec(FOC_MUL,   4,   2,  4,   99, -1,  1,    0, 0,  0,    5);
    add_vec(FOC_ADD,   6,   2,  7,   4,  -1,  1,    1, 0,  4,    5);
    add_vec(FOC_CVT,   2,   5,  2,   6,  -1,  1,    1, 0,  3,    5);
    add_vec(FOC_ADD,   9,   6,  9,   6,  -1,  1,    1, 0,  4,    6);
`ifdef THOR_FPU_DIVSQRT_EN
    add_vec(FOC_DIV,   2,   8,  2,   99, -1,  1,    0, 0,  0,    24);
    add_vec(FOC_DIV,   2,   8,  3,   24, -1,  1,    1, 0,  24,   25);
    add_vec(FOC_SQRT,  10, -1,  0,   0,  -1,  1,    1, 0,  32,   33);
`else
    add_vec(FOC_SQRT,  0,  -1,  0,   3,  -1,  0,    1, 1,  1,    3);
    add_vec(FOC_DIV,   2,   2,  2,   99, -1,  0,    1, 1,  1,    2);
`endif

    repeat (2) @(negedge clk);
    chk("rst_idle",     32'(sif.fpu_idle),  1);
    chk("rst_start",    32'(sif.fpu_start), 0);
    chk("rst_fpu_op",   32'(sif.fpu_op),    32'(FOC_ADD));
    chk("rst_busy_ndx", 32'(sif.busy_ndx),  0);
    chk("rst_wb_ndx",   32'(sif.wb_ndx),    0);
    chk("rst_wb_req",   32'(sif.wb_req),    0);
    chk("rst_wb_exc",   32'(sif.wb_exc),    0);
    rst = 1'b0;

    // Reset asserted while an operation is in EXEC
    @(negedge clk);
    sif.issue_v   = 1'b1;
    sif.issue_ndx = que_ndx_t'(9);
    sif.issue_op  = FOC_MUL;
    @(negedge clk);
    sif.issue_v = 1'b0;
    chk("mid_busy", 32'(sif.fpu_idle), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_idle",   32'(sif.fpu_idle),  1);
    chk("mid_rst_wb_req", 32'(sif.wb_req),    0);
    chk("mid_rst_start",  32'(sif.fpu_start), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_rst_stays_idle", 32'(sif.fpu_idle), 1);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], i);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
